pipe_hazard_ctrl: RTL and testbench

Parametrised hazard-control unit for the 5-stage RV32I pipeline, replacing the inline stall/squash logic in the core top level. A per-register scoreboard of countdown counters lets one load-use interlock cover any DMEM load latency. Adds a DMEM wait-state handshake that freezes the pipeline, and a saturating stall-cycle performance counter. Outputs drive the stall/squash inputs of stage_fetch, stage_decode, stage_ex and stage_ma, and the writeback enable gate.

---
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/squash control for the 5-stage RV32I pipeline.
// A per-register scoreboard of down-counters tracks how many more cycles a
// load result is unavailable. One interlock check therefore covers any DMEM
// load latency. A DMEM wait state freezes IF..MA and bubbles WB. A saturating
// counter accumulates the cycles in which any stage is held.
module pipe_hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 32,
  localparam int AW = $clog2(NUM_REGS),
  localparam int LW = $clog2(LOAD_LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [AW-1:0]    id_rs1_addr_i,
  input  logic [AW-1:0]    id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [AW-1:0]    id_rd_addr_i,
  input  logic             id_rd_wr_en_i,
  input  logic             id_is_load_i,
  input  logic             id_jal_i,
  input  logic             ex_redirect_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       squash_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  // Stage bit positions in stall_o / squash_o.
  localparam int S_IF = 0;
  localparam int S_ID = 1;
  localparam int S_EX = 2;
  localparam int S_MA = 3;
  localparam int S_WB = 4;

  logic [NUM_REGS-1:0][LW-1:0] w_busy;
  logic                        w_mem_wait;
  logic                        w_rs1_busy;
  logic                        w_rs2_busy;
  logic                        w_load_use;
  logic                        w_issue;
  logic                        w_advance;
  logic                        w_rd_update;
  logic [LW-1:0]               w_rd_val;
  logic [CNT_W-1:0]            r_stall_cycles;

  // A DMEM access still outstanding holds everything up to MA.
  assign w_mem_wait = dmem_req_i && !dmem_ack_i;
  assign w_advance  = !w_mem_wait;

  // Interlock: a read source whose producing load has not yet delivered.
  assign w_rs1_busy = id_rs1_used_i && (w_busy[id_rs1_addr_i] != '0);
  assign w_rs2_busy = id_rs2_used_i && (w_busy[id_rs2_addr_i] != '0);
  assign w_load_use = id_valid_i && (w_rs1_busy || w_rs2_busy);

  // Priority: reset, mem wait, redirect, load-use, jal.
  always_comb begin
    stall_o  = '0;
    squash_o = '0;
    if (!rst_ni) begin
      squash_o = 5'b11111;
    end else if (w_mem_wait) begin
      stall_o[S_IF] = 1'b1;
      stall_o[S_ID] = 1'b1;
      stall_o[S_EX] = 1'b1;
      stall_o[S_MA] = 1'b1;
      squash_o[S_WB] = 1'b1;
    end else if (ex_redirect_i) begin
      // Wrong-path fetch and decode are dropped; this also cancels any
      // load-use stall, since the ID instruction will never issue.
      squash_o[S_IF] = 1'b1;
      squash_o[S_ID] = 1'b1;
    end else if (w_load_use) begin
      // Hold IF/ID and feed a bubble into EX; a pending JAL waits too.
      stall_o[S_IF]  = 1'b1;
      stall_o[S_ID]  = 1'b1;
      squash_o[S_EX] = 1'b1;
    end else if (id_jal_i) begin
      squash_o[S_IF] = 1'b1;
    end
  end

  // An instruction leaves ID only when it is neither held nor squashed.
  assign w_issue = id_valid_i && !stall_o[S_ID] && !squash_o[S_ID];

  // Loads arm the destination counter; other writers clear it so a newer
  // forwardable value is not blocked by an older in-flight load (WAW).
  assign w_rd_update = w_issue && (id_is_load_i || id_rd_wr_en_i);
  assign w_rd_val    = id_is_load_i ? LW'(LOAD_LATENCY) : '0;

  // Register 0 is hardwired and never busy.
  assign w_busy[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    logic          w_hit;
    logic [LW-1:0] r_cnt;

    assign w_hit = w_rd_update && (id_rd_addr_i == AW'(r));

    // Issue write wins over the per-cycle countdown; both freeze in mem wait.
    always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_cnt <= w_rd_val;
      end else if (w_advance && (r_cnt != '0)) begin
        r_cnt <= r_cnt - LW'(1);
      end
    end

    assign w_busy[r] = r_cnt;
  end

  // Count every cycle with any hold, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cycles <= '0;
    end else if ((stall_o != '0) && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles_o = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Three instances share one stimulus:
// u1 (LOAD_LATENCY=1), u3 (LOAD_LATENCY=3) and u4 (LOAD_LATENCY=1, CNT_W=4).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       id_valid;
  logic [4:0] rs1, rs2, rd;
  logic       rs1_used, rs2_used, rd_wr_en, is_load, jal, redirect;
  logic       dmem_req, dmem_ack;

  logic [4:0]  u1_stall, u1_squash, u3_stall, u3_squash, u4_stall, u4_squash;
  logic [31:0] u1_cnt, u3_cnt;
  logic [3:0]  u4_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NUM_REGS(32), .LOAD_LATENCY(1), .CNT_W(32)) u1 (
    .clk(clk), .rst_ni(rst_ni), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_rd_addr_i(rd), .id_rd_wr_en_i(rd_wr_en), .id_is_load_i(is_load),
    .id_jal_i(jal), .ex_redirect_i(redirect),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .stall_o(u1_stall), .squash_o(u1_squash), .stall_cycles_o(u1_cnt));

  pipe_hazard_ctrl #(.NUM_REGS(32), .LOAD_LATENCY(3), .CNT_W(32)) u3 (
    .clk(clk), .rst_ni(rst_ni), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_rd_addr_i(rd), .id_rd_wr_en_i(rd_wr_en), .id_is_load_i(is_load),
    .id_jal_i(jal), .ex_redirect_i(redirect),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .stall_o(u3_stall), .squash_o(u3_squash), .stall_cycles_o(u3_cnt));

  pipe_hazard_ctrl #(.NUM_REGS(32), .LOAD_LATENCY(1), .CNT_W(4)) u4 (
    .clk(clk), .rst_ni(rst_ni), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_rd_addr_i(rd), .id_rd_wr_en_i(rd_wr_en), .id_is_load_i(is_load),
    .id_jal_i(jal), .ex_redirect_i(redirect),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .stall_o(u4_stall), .squash_o(u4_squash), .stall_cycles_o(u4_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    rd = '0; rd_wr_en = 1'b0; is_load = 1'b0; jal = 1'b0; redirect = 1'b0;
    dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] a1, input logic u_1, input logic [4:0] a2,
                        input logic u_2, input logic [4:0] d, input logic wr,
                        input logic ld);
    id_valid = 1'b1; rs1 = a1; rs1_used = u_1; rs2 = a2; rs2_used = u_2;
    rd = d; rd_wr_en = wr; is_load = ld; jal = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    idle();
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_stall", 32'(u1_stall), 32'h00);
    chk("rst_squash", 32'(u1_squash), 32'h1f);
    chk("rst_cnt", u1_cnt, 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    #1;
    chk("rel_stall", 32'(u1_stall), 32'h00);
    chk("rel_squash", 32'(u1_squash), 32'h00);
    tick();

    // lw x5 ; add x6,x5,x1 with LOAD_LATENCY=1
    set_id(5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
    #1 chk("A_lw_stall", 32'(u1_stall), 32'h00);
    tick();
    set_id(5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    #1 chk("A_lu_stall", 32'(u1_stall), 32'h03);
    chk("A_lu_squash", 32'(u1_squash), 32'h04);
    tick();
    #1 chk("A_issue_stall", 32'(u1_stall), 32'h00);
    chk("A_issue_squash", 32'(u1_squash), 32'h00);
    tick();
    idle();
    #1 chk("A_cnt", u1_cnt, 32'd1);
    tick();

    // LOAD_LATENCY=3: lw x5 ; nop ; add x6,x5,x5 -> 2 stalls
    do_reset();
    set_id(5'd2, 1, 5'd0, 0, 5'd5, 1, 1); tick();
    set_id(5'd0, 0, 5'd0, 0, 5'd0, 0, 0); tick();
    set_id(5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
    #1 chk("B_st1", 32'(u3_stall), 32'h03);
    tick();
    #1 chk("B_st2", 32'(u3_stall), 32'h03);
    tick();
    #1 chk("B_go", 32'(u3_stall), 32'h00);
    tick();
    idle();
    #1 chk("B_cnt", u3_cnt, 32'd2);
    tick();

    // Same sequence loading x0 never stalls
    do_reset();
    set_id(5'd2, 1, 5'd0, 0, 5'd0, 1, 1); tick();
    set_id(5'd0, 0, 5'd0, 0, 5'd0, 0, 0); tick();
    set_id(5'd0, 1, 5'd0, 1, 5'd6, 1, 0);
    #1 chk("B0_stall", 32'(u3_stall), 32'h00);
    tick();
    idle();
    #1 chk("B0_cnt", u3_cnt, 32'd0);
    tick();

    // Mem wait of 4 cycles on top of a pending load-use
    do_reset();
    set_id(5'd2, 1, 5'd0, 0, 5'd5, 1, 1); tick();
    set_id(5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    dmem_req = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("C_wait_stall%0d", i), 32'(u1_stall), 32'h0f);
      chk($sformatf("C_wait_squash%0d", i), 32'(u1_squash), 32'h10);
      tick();
    end
    dmem_ack = 1'b1;
    #1 chk("C_lu_stall", 32'(u1_stall), 32'h03);
    chk("C_lu_squash", 32'(u1_squash), 32'h04);
    tick();
    dmem_req = 1'b0; dmem_ack = 1'b0;
    #1 chk("C_go", 32'(u1_stall), 32'h00);
    tick();
    idle();
    #1 chk("C_cnt", u1_cnt, 32'd5);
    tick();

    // Redirect with load-use: no stall, ID load does not arm x8
    do_reset();
    set_id(5'd2, 1, 5'd0, 0, 5'd5, 1, 1); tick();
    set_id(5'd5, 1, 5'd0, 0, 5'd8, 1, 1);
    redirect = 1'b1;
    #1 chk("D_rd_stall", 32'(u1_stall), 32'h00);
    chk("D_rd_squash", 32'(u1_squash), 32'h03);
    tick();
    redirect = 1'b0;
    set_id(5'd8, 1, 5'd0, 0, 5'd9, 1, 0);
    #1 chk("D_x8_stall", 32'(u1_stall), 32'h00);
    chk("D_x8_squash", 32'(u1_squash), 32'h00);
    tick();
    idle();
    dmem_req = 1'b1; redirect = 1'b1;
    #1 chk("D_mw_stall", 32'(u1_stall), 32'h0f);
    chk("D_mw_squash", 32'(u1_squash), 32'h10);
    tick();
    dmem_ack = 1'b1;
    #1 chk("D_after_stall", 32'(u1_stall), 32'h00);
    chk("D_after_squash", 32'(u1_squash), 32'h03);
    tick();
    idle();

    // WAW: lw x7 ; addi x7 ; add x8,x7,x7 -> no stall
    do_reset();
    set_id(5'd2, 1, 5'd0, 0, 5'd7, 1, 1); tick();
    set_id(5'd1, 1, 5'd0, 0, 5'd7, 1, 0);
    #1 chk("E_addi_stall", 32'(u3_stall), 32'h00);
    tick();
    set_id(5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
    #1 chk("E_use_stall3", 32'(u3_stall), 32'h00);
    chk("E_use_stall1", 32'(u1_stall), 32'h00);
    tick();
    idle();
    id_valid = 1'b1; jal = 1'b1;
    #1 chk("E_jal_squash", 32'(u1_squash), 32'h01);
    chk("E_jal_stall", 32'(u1_stall), 32'h00);
    tick();

    // JAL is ignored while load-use holds
    do_reset();
    set_id(5'd2, 1, 5'd0, 0, 5'd5, 1, 1); tick();
    set_id(5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
    jal = 1'b1;
    #1 chk("J_lu_squash", 32'(u1_squash), 32'h04);
    tick();
    #1 chk("J_go_squash", 32'(u1_squash), 32'h01);
    tick();

    // Back-to-back loads to x5 restart the countdown
    do_reset();
    set_id(5'd2, 1, 5'd0, 0, 5'd5, 1, 1); tick();
    set_id(5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
    #1 chk("L_second_stall", 32'(u3_stall), 32'h00);
    tick();
    set_id(5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    tick(); tick();
    #1 chk("L_third_stall", 32'(u3_stall), 32'h03);
    tick();
    #1 chk("L_go", 32'(u3_stall), 32'h00);
    tick();

    // Saturation with CNT_W=4, then asynchronous reset mid-stall
    do_reset();
    dmem_req = 1'b1;
    repeat (20) tick();
    #1 chk("F_sat4", 32'(u4_cnt), 32'd15);
    chk("F_cnt32", u1_cnt, 32'd20);
    chk("F_stall", 32'(u4_stall), 32'h0f);
    rst_ni = 1'b0;
    #1 chk("F_rst_squash", 32'(u4_squash), 32'h1f);
    chk("F_rst_stall", 32'(u4_stall), 32'h00);
    chk("F_rst_cnt4", 32'(u4_cnt), 32'd0);
    chk("F_rst_cnt32", u1_cnt, 32'd0);
    idle();
    tick();
    rst_ni = 1'b1;
    #1 chk("F_rel_stall", 32'(u4_stall), 32'h00);
    chk("F_rel_squash", 32'(u4_squash), 32'h00);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
